// File: rtl/spi_camera_pkg.sv
// Shared FSM encoding and register-map constants for the SPI camera responder.
// Pure declarations; no timing or flow control.
package spi_camera_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_RDATA = 3'd3,
      ST_BURST = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int         CMD_WRITE_BIT  = 7;
   localparam logic [6:0] ADDR_ID        = 7'h00;
   localparam logic [6:0] ADDR_FIFO_CTRL = 7'h04;
   localparam int         NUM_REGS       = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// 2-flop synchronizer with rise/fall detect; edges and level valid 2 clk after the pin changes.
// No backpressure: one-clk edge pulses, consumer must take them when they occur.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_camera_responder.sv
// SPI mode-0 register responder (ID, 7 r/w regs, pattern burst when SPI_RESP_BURST_EN is defined).
// ~3 clk pin sync, wr_valid 1 clk after the synced 8th data rise; no backpressure, the initiator paces everything.
module spi_camera_responder
   import spi_camera_pkg::*;
#(
   parameter logic [7:0] ID_VALUE   = 8'h55,
   parameter logic [6:0] BURST_ADDR = 7'h3C
) (
   input  logic       clk,
   input  logic       reset_rtl_0,
   input  logic       camera_spi_sclk,
   input  logic       camera_spi_ss,
   input  logic       camera_spi_mosi,
   output logic       camera_spi_miso,
   output logic       wr_valid,
   output logic [2:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       burst_active
);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_CMD   = ST_CMD;
   localparam logic [2:0] S_WDATA = ST_WDATA;
   localparam logic [2:0] S_RDATA = ST_RDATA;
   localparam logic [2:0] S_BURST = ST_BURST;
   localparam logic [2:0] S_DONE  = ST_DONE;

   logic       sclk_lvl, sclk_rise, sclk_fall;
   logic       ss_lvl, ss_rise, ss_fall;
   logic       mosi_meta_q, mosi_sync_q;

   logic [2:0] state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] tx_q, tx_d;
   logic       load_q, load_d;
   logic       miso_q, miso_d;
   logic       wr_valid_q, wr_valid_d;
   logic [2:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] regs_q [NUM_REGS];
   logic [7:0] regs_d [NUM_REGS];
   logic [1:0] settle_q, settle_d;
   logic       armed_q, armed_d;
   logic [7:0] rx_byte, rd_byte, out_byte;
`ifdef SPI_RESP_BURST_EN
   logic [7:0] pat_q, pat_d;
`endif

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk_i(clk), .rst_ni(reset_rtl_0), .async_i(camera_spi_sclk),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
      .clk_i(clk), .rst_ni(reset_rtl_0), .async_i(camera_spi_ss),
      .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   always_comb begin
      rd_byte = 8'h00;
      if (addr_q == ADDR_ID) begin
         rd_byte = ID_VALUE;
      end else if (addr_q < 7'(NUM_REGS)) begin
         rd_byte = regs_q[addr_q[2:0]];
      end
`ifndef SPI_RESP_BURST_EN
      if (addr_q == BURST_ADDR) rd_byte = 8'h00;
`endif
   end

   // Only a select that falls after reset has settled and ss was seen high counts as a new frame.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      tx_d       = tx_q;
      load_d     = load_q;
      miso_d     = miso_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      regs_d     = regs_q;
      settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      armed_d    = armed_q | ((settle_q == 2'd3) & ss_lvl);
      rx_byte    = {shift_q, mosi_sync_q};
      out_byte   = load_q ? rd_byte : tx_q;
`ifdef SPI_RESP_BURST_EN
      pat_d      = pat_q;
      if (state_q == S_BURST && load_q) out_byte = pat_q;
`endif

      if (ss_rise) begin
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
         shift_d   = 7'd0;
         load_d    = 1'b0;
         miso_d    = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               miso_d    = 1'b0;
               bit_cnt_d = 3'd0;
               shift_d   = 7'd0;
               if (ss_fall && armed_q && !sclk_lvl) state_d = S_CMD;
            end
            S_CMD: begin
               if (sclk_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     addr_d = rx_byte[6:0];
                     if (rx_byte[CMD_WRITE_BIT]) begin
                        state_d = S_WDATA;
`ifdef SPI_RESP_BURST_EN
                     end else if (rx_byte[6:0] == BURST_ADDR) begin
                        state_d = S_BURST;
                        load_d  = 1'b1;
`endif
                     end else begin
                        state_d = S_RDATA;
                        load_d  = 1'b1;
                     end
                  end
               end
            end
            S_WDATA: begin
               if (sclk_rise) begin
                  shift_d   = rx_byte[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = S_DONE;
                     if (addr_q != ADDR_ID && addr_q < 7'(NUM_REGS)) begin
                        wr_valid_d             = 1'b1;
                        wr_addr_d              = addr_q[2:0];
                        wr_data_d              = rx_byte;
                        regs_d[addr_q[2:0]]    = rx_byte;
`ifdef SPI_RESP_BURST_EN
                        if (addr_q == ADDR_FIFO_CTRL && rx_byte[0]) pat_d = 8'h00;
`endif
                     end
                  end
               end
            end
            S_RDATA: begin
               if (sclk_fall) begin
                  miso_d = out_byte[7];
                  tx_d   = {out_byte[6:0], 1'b0};
                  load_d = 1'b0;
               end
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_d = S_DONE;
                     miso_d  = 1'b0;
                  end
               end
            end
            S_BURST: begin
`ifdef SPI_RESP_BURST_EN
               if (sclk_fall) begin
                  miso_d = out_byte[7];
                  tx_d   = {out_byte[6:0], 1'b0};
                  load_d = 1'b0;
               end
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     pat_d  = pat_q + 8'd1;
                     load_d = 1'b1;
                  end
               end
`else
               state_d = S_IDLE;
               miso_d  = 1'b0;
`endif
            end
            S_DONE: begin
               miso_d = 1'b0;
            end
            default: begin
               state_d = S_IDLE;
               miso_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_rtl_0) begin
      if (!reset_rtl_0) begin
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         state_q     <= S_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 7'd0;
         addr_q      <= 7'd0;
         tx_q        <= 8'd0;
         load_q      <= 1'b0;
         miso_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= 3'd0;
         wr_data_q   <= 8'd0;
         settle_q    <= 2'd0;
         armed_q     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
`ifdef SPI_RESP_BURST_EN
         pat_q       <= 8'h00;
`endif
      end else begin
         mosi_meta_q <= camera_spi_mosi;
         mosi_sync_q <= mosi_meta_q;
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         addr_q      <= addr_d;
         tx_q        <= tx_d;
         load_q      <= load_d;
         miso_q      <= miso_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         settle_q    <= settle_d;
         armed_q     <= armed_d;
         regs_q      <= regs_d;
`ifdef SPI_RESP_BURST_EN
         pat_q       <= pat_d;
`endif
      end
   end

   assign camera_spi_miso = miso_q;
   assign wr_valid        = wr_valid_q;
   assign wr_addr         = wr_addr_q;
   assign wr_data         = wr_data_q;
`ifdef SPI_RESP_BURST_EN
   assign burst_active    = (state_q == S_BURST);
`else
   assign burst_active    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_camera_responder.sv
// Scoreboard bench for spi_camera_responder: SPI mode-0 initiator, expected writes/reads queued at stimulus time.
// Burst checks are built only when SPI_RESP_BURST_EN is defined.
module tb_spi_camera_responder;

   localparam int HALF = 50;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk  = 1'b0;
   logic       ss    = 1'b1;
   logic       mosi  = 1'b0;
   logic       miso, wr_valid, burst_active;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [10:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   logic [7:0]  m_reg  [8];
`ifdef SPI_RESP_BURST_EN
   logic [7:0]  m_pat;
`endif

   always #5 clk = ~clk;

   spi_camera_responder dut (
      .clk            (clk),
      .reset_rtl_0    (rst_n),
      .camera_spi_sclk(sclk),
      .camera_spi_ss  (ss),
      .camera_spi_mosi(mosi),
      .camera_spi_miso(miso),
      .wr_valid       (wr_valid),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .burst_active   (burst_active)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && wr_valid === 1'b1) begin
         chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
         if (exp_wr.size() != 0) chk("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_wr.pop_front()));
      end
   end

   task automatic xfer_n(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int k = 0; k < n; k++) begin
         mosi = tx[7-k];
         #HALF;
         rx[7-k] = miso;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
      xfer_n(tx, 8, rx);
   endtask

   task automatic begin_tx();
      @(negedge clk);
      ss = 1'b0;
      #80;
   endtask

   task automatic end_tx();
      #HALF;
      ss = 1'b1;
      #100;
   endtask

   task automatic wr_reg(input logic [6:0] a, input logic [7:0] v, input bit commit);
      logic [7:0] d;
      if (commit) begin
         exp_wr.push_back({a[2:0], v});
         m_reg[a[2:0]] = v;
      end
      begin_tx();
      xfer({1'b1, a}, d);
      xfer(v, d);
      end_tx();
   endtask

   task automatic rd_reg(input logic [6:0] a, input logic [7:0] e);
      logic [7:0] d;
      begin_tx();
      xfer({1'b0, a}, d);
      exp_rd.push_back(e);
      xfer(8'h00, d);
      end_tx();
      chk($sformatf("rd_%02h", a), 32'(d), 32'(exp_rd.pop_front()));
   endtask

`ifdef SPI_RESP_BURST_EN
   task automatic burst(input int n);
      logic [7:0] d;
      begin_tx();
      xfer(8'h3C, d);
      chk("burst_active_on", 32'(burst_active), 32'd1);
      for (int i = 0; i < n; i++) begin
         exp_rd.push_back(m_pat);
         m_pat = m_pat + 8'd1;
         xfer(8'h00, d);
         chk("burst_byte", 32'(d), 32'(exp_rd.pop_front()));
      end
      end_tx();
      chk("burst_active_off", 32'(burst_active), 32'd0);
   endtask
`endif

   task automatic do_reset();
      ss   = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, v, id;
      id = 8'h55;
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
`ifdef SPI_RESP_BURST_EN
      m_pat = 8'h00;
`endif

      #20;
      chk("rst_miso", 32'(miso), 32'd0);
      chk("rst_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_burst_active", 32'(burst_active), 32'd0);
      do_reset();

      wr_reg(7'h03, 8'hA5, 1'b1);
      rd_reg(7'h03, 8'hA5);

      rd_reg(7'h00, id);
      wr_reg(7'h00, 8'h12, 1'b0);
      rd_reg(7'h00, id);
      wr_reg(7'h0A, 8'h77, 1'b0);
      rd_reg(7'h0A, 8'h00);
      rd_reg(7'h7F, 8'h00);

      for (int i = 1; i < 8; i++) begin
         v = 8'($urandom_range(0, 255));
         wr_reg(7'(i), v, 1'b1);
      end
      for (int i = 1; i < 8; i++) rd_reg(7'(i), m_reg[i]);

      // Write to reg 5 cut short after 5 data bits
      begin_tx();
      xfer(8'h85, d);
      v = ~m_reg[5];
      xfer_n(v, 5, d);
      #HALF;
      ss = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_wr_miso", 32'(miso), 32'd0);
      #100;
      rd_reg(7'h05, m_reg[5]);

      // Read of ID cut short: miso must drop once ss goes high
      begin_tx();
      xfer(8'h00, d);
      xfer_n(8'h00, 3, d);
      #HALF;
      chk("rd_midbyte_miso", 32'(miso), 32'(id[4]));
      ss = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_rd_miso", 32'(miso), 32'd0);
      #100;

`ifdef SPI_RESP_BURST_EN
      burst(4);
      burst(4);
      wr_reg(7'h04, 8'h02, 1'b1);
      burst(1);
      wr_reg(7'h04, 8'h01, 1'b1);
      m_pat = 8'h00;
      burst(2);
      burst(252);
      burst(3);

      begin_tx();
      xfer(8'h3C, d);
      exp_rd.push_back(m_pat);
      xfer(8'h00, d);
      chk("burst_pre_reset", 32'(d), 32'(exp_rd.pop_front()));
      xfer_n(8'h00, 3, d);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_burst_active_mid", 32'(burst_active), 32'd0);
      chk("rst_burst_miso_mid", 32'(miso), 32'd0);
      chk("rst_burst_wr_valid_mid", 32'(wr_valid), 32'd0);
      do_reset();
      m_pat = 8'h00;
      burst(2);
`else
      begin_tx();
      xfer(8'h3C, d);
      chk("nb_burst_active", 32'(burst_active), 32'd0);
      exp_rd.push_back(8'h00);
      xfer(8'h00, d);
      chk("nb_rd_3c", 32'(d), 32'(exp_rd.pop_front()));
      xfer(8'h00, d);
      chk("nb_done_zero", 32'(d), 32'd0);
      end_tx();
`endif

      // Reset in the middle of a write: no commit, registers cleared
      begin_tx();
      xfer(8'h86, d);
      xfer_n(8'hFF, 4, d);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_miso", 32'(miso), 32'd0);
      chk("rst_mid_wr_valid", 32'(wr_valid), 32'd0);
      chk("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_mid_wr_data", 32'(wr_data), 32'd0);
      do_reset();
      rd_reg(7'h06, m_reg[6]);
      rd_reg(7'h03, m_reg[3]);
      rd_reg(7'h00, id);

      repeat (10) @(negedge clk);
      chk("wr_left", 32'(exp_wr.size()), 32'd0);
      chk("rd_left", 32'(exp_rd.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
